// File: rtl/mc_cpu_core.sv
// mc_cpu_core -- multi-cycle MIPS-subset CPU core with external memory buses.
//
// State advances on the falling edge of CLK; Reset is asynchronous, active low.
// Instruction and data memories sit outside the core behind req/ack handshakes,
// so any number of wait states is tolerated.
//
// Ports:
//   CLK, Reset                    clock (negedge active), async active-low reset
//   imem_req/addr/rdata/ack       instruction fetch bus (addr = PC)
//   dmem_req/we/addr/wdata/rdata/ack  data bus (addr = ALUOut, wdata = B)
//   retire                        pulse in the final cycle of each instruction
//   halted, illegal               HALT state, sticky undefined-opcode flag
//   dbg_pc, dbg_state, dbg_reg    debug taps for the board 7-segment mux
module mc_cpu_core #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DBG_REG  = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              retire,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [2:0]        dbg_state,
    output logic [7:0]        dbg_reg
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EXE  = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd7;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [4:0] DBG_IDX = DBG_REG[4:0];

    // One-hot instruction class, decoded from IR and used from ID onwards.
    typedef struct packed {
        logic r_alu;
        logic imm_alu;
        logic lw;
        logic sw;
        logic branch;
        logic j;
        logic jal;
        logic jr;
        logic halt;
        logic bad;
    } dec_t;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir, a, b, alu_out, mdr;
    logic [31:0]       rf [32];

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, sa, wb_idx;
    logic [31:0]       imm_s, imm_z, alu_res;
    logic [ADDR_W-1:0] pc_plus4, br_tgt, jmp_tgt;
    logic              br_taken;
    dec_t              dec;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign sa     = ir[10:6];
    assign funct  = ir[5:0];
    assign imm_s  = {{16{ir[15]}}, ir[15:0]};
    assign imm_z  = {16'h0000, ir[15:0]};
    assign wb_idx = (op == OP_R) ? rd : rt;

    // All PC arithmetic is done at ADDR_W bits so it wraps naturally.
    assign pc_plus4 = pc + ADDR_W'(4);
    // In EXE the PC already points past the branch.
    assign br_tgt   = pc + ADDR_W'({imm_s[29:0], 2'b00});
    // Region bits come from PC+4 (already in pc during ID), then truncate.
    assign jmp_tgt  = ADDR_W'({4'(32'(pc) >> 28), ir[25:0], 2'b00});
    assign br_taken = (op == OP_BEQ) ? (a == b) : (a != b);

    always_comb begin
        dec = '0;
        case (op)
            OP_R: begin
                case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL: dec.r_alu = 1'b1;
                    F_JR:    dec.jr  = 1'b1;
                    default: dec.bad = 1'b1;
                endcase
            end
            OP_ADDI, OP_ORI: dec.imm_alu = 1'b1;
            OP_LW:           dec.lw      = 1'b1;
            OP_SW:           dec.sw      = 1'b1;
            OP_BEQ, OP_BNE:  dec.branch  = 1'b1;
            OP_J:            dec.j       = 1'b1;
            OP_JAL:          dec.jal     = 1'b1;
            OP_HALT:         dec.halt    = 1'b1;
            default:         dec.bad     = 1'b1;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_R: begin
                case (funct)
                    F_ADD:   alu_res = a + b;
                    F_SUB:   alu_res = a - b;
                    F_AND:   alu_res = a & b;
                    F_OR:    alu_res = a | b;
                    F_SLT:   alu_res = {31'b0, $signed(a) < $signed(b)};
                    F_SLL:   alu_res = b << sa;
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a + imm_s;
            OP_ORI:                alu_res = a | imm_z;
            default:               alu_res = '0;
        endcase
    end

    always_ff @(negedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IF;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            illegal <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_IF: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        pc    <= pc_plus4;
                        state <= S_ID;
                    end
                end
                S_ID: begin
                    // r0 is never written, so reading rf[0] always yields 0.
                    a     <= rf[rs];
                    b     <= rf[rt];
                    state <= S_EXE;
                    if (dec.j || dec.jal) begin
                        pc    <= jmp_tgt;
                        state <= S_IF;
                    end
                    if (dec.jal) rf[31] <= 32'(pc);
                    if (dec.jr) begin
                        pc    <= ADDR_W'(rf[rs]);
                        state <= S_IF;
                    end
                    if (dec.halt || dec.bad) state <= S_HALT;
                    if (dec.bad) illegal <= 1'b1;
                end
                S_EXE: begin
                    alu_out <= alu_res;
                    if (dec.branch) begin
                        if (br_taken) pc <= br_tgt;
                        state <= S_IF;
                    end else if (dec.lw || dec.sw) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (dec.lw) mdr <= dmem_rdata;
                        state <= dec.lw ? S_WB : S_IF;
                    end
                end
                S_WB: begin
                    if (wb_idx != 5'd0) rf[wb_idx] <= dec.lw ? mdr : alu_out;
                    state <= S_IF;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

    // Requests decode straight from state; gating with Reset drops them the
    // moment reset is asserted, even though state is already IF.
    assign imem_req   = Reset && (state == S_IF);
    assign imem_addr  = pc;
    assign dmem_req   = Reset && (state == S_MEM);
    assign dmem_we    = dmem_req && dec.sw;
    assign dmem_addr  = ADDR_W'(alu_out);
    assign dmem_wdata = b;

    always_comb begin
        retire = 1'b0;
        case (state)
            S_ID:    retire = dec.j || dec.jal || dec.jr;
            S_EXE:   retire = dec.branch;
            S_MEM:   retire = dec.sw && dmem_ack;
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    assign halted    = (state == S_HALT);
    assign dbg_pc    = pc;
    assign dbg_state = state;
    assign dbg_reg   = rf[DBG_IDX][7:0];

endmodule

// File: tb/tb_mc_cpu_core.sv
// Bench for mc_cpu_core: behavioural wait-state memories, a scoreboard of
// expected retire events (PC at retire, cycles since previous retire) and
// data-bus transactions, plus directed checks of reset / halt / illegal.
module tb_mc_cpu_core;

    localparam int AW = 16;
    localparam logic [AW-1:0] RST_PC = 16'h0040;

    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic          imem_req, imem_ack = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = '0;
    logic          dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata, dmem_rdata = '0;
    logic          retire, halted, illegal;
    logic [AW-1:0] dbg_pc;
    logic [2:0]    dbg_state;
    logic [7:0]    dbg_reg;

    mc_cpu_core #(.ADDR_W(AW), .RESET_PC(RST_PC), .DBG_REG(1)) dut (
        .CLK(CLK), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .retire(retire), .halted(halted), .illegal(illegal),
        .dbg_pc(dbg_pc), .dbg_state(dbg_state), .dbg_reg(dbg_reg)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [AW-1:0] pc; int gap; } ret_t;
    typedef struct { logic [AW-1:0] addr; logic we; logic [31:0] wdata; } dm_t;
    ret_t ret_q[$];
    dm_t  dm_q[$];

    int n_chk = 0, n_pass = 0;
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0, n10 = 0, cyc = 0, last_ret = 0;
    logic manual = 1'b0;
    logic [31:0] patch_word = '0;
    logic [31:0] imem [256];
    logic [31:0] dmem [256];

    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic fail_evt(input string nm, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: got event %h but none expected", nm, act);
    endtask

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sa, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction
    function automatic logic [31:0] ej(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic put(input logic [AW-1:0] addr, input logic [31:0] w);
        imem[addr[9:2]] = w;
    endtask
    task automatic exp_ret(input logic [AW-1:0] addr, input int gap);
        ret_t e;
        e.pc = addr + 16'd4;
        e.gap = gap;
        ret_q.push_back(e);
    endtask
    task automatic ins(input logic [AW-1:0] addr, input logic [31:0] w, input int gap);
        put(addr, w);
        exp_ret(addr, gap);
    endtask
    task automatic exp_dm(input logic [AW-1:0] addr, input logic we, input logic [31:0] wd);
        dm_t e;
        e.addr = addr; e.we = we; e.wdata = wd;
        dm_q.push_back(e);
    endtask
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin imem[i] = HALT_W; dmem[i] = '0; end
        n10 = 0;
    endtask

    // Memory models: ack after iwait/dwait extra cycles of a held request.
    always @(posedge CLK) begin
        if (manual) begin
            icnt = 0;
        end else if (imem_req) begin
            if (icnt == iwait) begin
                imem_ack = 1'b1;
                imem_rdata = imem[imem_addr[9:2]];
                icnt = 0;
                if (imem_addr == 16'h0010) begin
                    n10++;
                    if (n10 == 2) imem[4] = patch_word;
                end
            end else begin
                imem_ack = 1'b0;
                icnt++;
            end
        end else begin
            imem_ack = 1'b0;
            icnt = 0;
        end
        if (dmem_req) begin
            if (dcnt == dwait) begin
                dmem_ack = 1'b1;
                if (dmem_we) dmem[dmem_addr[9:2]] = dmem_wdata;
                else dmem_rdata = dmem[dmem_addr[9:2]];
                dcnt = 0;
            end else begin
                dmem_ack = 1'b0;
                dcnt++;
            end
        end else begin
            dmem_ack = 1'b0;
            dcnt = 0;
        end
    end

    // Monitor: scoreboard pops plus request-stability checks.
    logic          pi_req = 0, pi_ack = 0, pd_req = 0, pd_ack = 0, pd_we = 0;
    logic [AW-1:0] pi_addr = '0, pd_addr = '0;
    logic [31:0]   pd_wdata = '0;
    always @(posedge CLK) begin
        ret_t r;
        dm_t d;
        #1;
        cyc++;
        if (!Reset) begin
            last_ret = cyc;
            pi_req = 0;
            pd_req = 0;
        end else begin
            if (imem_req && pi_req && !pi_ack) chk("imem_addr_stable", 32'(imem_addr), 32'(pi_addr));
            if (dmem_req && pd_req && !pd_ack) begin
                chk("dmem_addr_stable", 32'(dmem_addr), 32'(pd_addr));
                chk("dmem_we_stable", 32'(dmem_we), 32'(pd_we));
                chk("dmem_wdata_stable", dmem_wdata, pd_wdata);
            end
            if (retire) begin
                if (ret_q.size() == 0) fail_evt("retire_unexpected", 32'(dbg_pc));
                else begin
                    r = ret_q.pop_front();
                    chk("retire_pc", 32'(dbg_pc), 32'(r.pc));
                    chk("retire_gap", 32'(cyc - last_ret), 32'(r.gap));
                end
                last_ret = cyc;
            end
            if (dmem_req && dmem_ack) begin
                if (dm_q.size() == 0) fail_evt("dmem_unexpected", 32'(dmem_addr));
                else begin
                    d = dm_q.pop_front();
                    chk("dmem_addr", 32'(dmem_addr), 32'(d.addr));
                    chk("dmem_we", 32'(dmem_we), 32'(d.we));
                    if (d.we) chk("dmem_wdata", dmem_wdata, d.wdata);
                end
            end
            pi_req = imem_req; pi_ack = imem_ack; pi_addr = imem_addr;
            pd_req = dmem_req; pd_ack = dmem_ack; pd_addr = dmem_addr;
            pd_we = dmem_we; pd_wdata = dmem_wdata;
        end
    end

    task automatic wait_halt(input string nm);
        int n = 0;
        while (!halted && n < 3000) begin @(posedge CLK); #2; n++; end
        chk(nm, 32'(halted), 32'd1);
    endtask

    task automatic check_no_req(input string nm);
        logic seen = 1'b0;
        repeat (10) begin @(posedge CLK); #2; if (imem_req || dmem_req) seen = 1'b1; end
        chk(nm, 32'(seen), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [4:0]  st_rt  [8] = '{5'd3, 5'd4, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd0};
    logic [31:0] st_val [8] = '{32'h2, 32'h1, 32'h8, 32'h5, 32'hFFFF_FFFD, 32'h50, 32'h8001, 32'h0};

    initial begin
        // ---------- Run A: ALU, stores, branches, jumps, halt (zero wait) ----------
        clear_mem();
        iwait = 0; dwait = 0;
        patch_word = ei(6'h05, 5'd1, 5'd1, 16'd100);
        ins(16'h40, ei(6'h08, 5'd0, 5'd1, 16'd5), 4);
        ins(16'h44, ei(6'h08, 5'd0, 5'd2, 16'hFFFD), 4);
        ins(16'h48, er(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 4);
        ins(16'h4C, er(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A), 4);
        ins(16'h50, er(5'd1, 5'd2, 5'd7, 5'd0, 6'h22), 4);
        ins(16'h54, er(5'd1, 5'd2, 5'd8, 5'd0, 6'h24), 4);
        ins(16'h58, er(5'd1, 5'd2, 5'd9, 5'd0, 6'h25), 4);
        ins(16'h5C, er(5'd0, 5'd1, 5'd10, 5'd4, 6'h00), 4);
        ins(16'h60, ei(6'h0D, 5'd0, 5'd11, 16'h8001), 4);
        ins(16'h64, ei(6'h08, 5'd0, 5'd0, 16'd7), 4);
        for (int i = 0; i < 8; i++) begin
            ins(16'h68 + 16'(4 * i), ei(6'h2B, 5'd0, st_rt[i], 16'h80 + 16'(4 * i)), 4);
            exp_dm(16'h80 + 16'(4 * i), 1'b1, st_val[i]);
        end
        ins(16'h88, ej(6'h02, 26'h4), 2);
        put(16'h10, ei(6'h04, 5'd1, 5'd1, 16'hFFFF));
        exp_ret(16'h10, 3);   // beq taken, back to 0x10
        exp_ret(16'h10, 3);   // beq taken again
        exp_ret(16'h10, 3);   // patched bne, not taken
        ins(16'h14, ej(6'h02, 26'h8), 2);
        ins(16'h20, ej(6'h03, 26'h40), 2);
        ins(16'h100, ei(6'h2B, 5'd0, 5'd31, 16'h00A0), 4);
        exp_dm(16'hA0, 1'b1, 32'h24);
        ins(16'h104, er(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 2);
        put(16'h24, HALT_W);

        repeat (2) @(negedge CLK);
        @(posedge CLK); #2;
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        chk("rst_dmem_we", 32'(dmem_we), 0);
        chk("rst_retire", 32'(retire), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_state", 32'(dbg_state), 0);
        chk("rst_dbg_reg", 32'(dbg_reg), 0);
        chk("rst_pc", 32'(dbg_pc), 32'h40);
        @(negedge CLK); #1 Reset = 1'b1;
        @(posedge CLK); #2;
        chk("first_fetch_req", 32'(imem_req), 1);
        chk("first_fetch_addr", 32'(imem_addr), 32'h40);

        wait_halt("a_halted");
        chk("a_illegal", 32'(illegal), 0);
        chk("a_state", 32'(dbg_state), 32'd7);
        chk("a_dbg_reg", 32'(dbg_reg), 32'd5);
        check_no_req("a_halt_noreq");
        chk("a_ret_q_empty", 32'(ret_q.size()), 0);
        chk("a_dm_q_empty", 32'(dm_q.size()), 0);

        // ---------- Run B: sw/lw with 3 wait states, illegal opcode ----------
        Reset = 1'b0;
        clear_mem();
        iwait = 3; dwait = 3;
        ins(16'h40, ei(6'h08, 5'd0, 5'd1, 16'd5), 7);
        ins(16'h44, ei(6'h2B, 5'd0, 5'd1, 16'h0008), 10);
        exp_dm(16'h08, 1'b1, 32'h5);
        ins(16'h48, ei(6'h23, 5'd0, 5'd5, 16'h0008), 11);
        exp_dm(16'h08, 1'b0, 32'h0);
        ins(16'h4C, ei(6'h2B, 5'd0, 5'd5, 16'h000C), 10);
        exp_dm(16'h0C, 1'b1, 32'h5);
        put(16'h50, 32'hF800_0000);
        repeat (2) @(negedge CLK);
        #1 Reset = 1'b1;
        wait_halt("b_halted");
        chk("b_illegal", 32'(illegal), 1);
        chk("b_state", 32'(dbg_state), 32'd7);
        chk("b_dbg_reg", 32'(dbg_reg), 32'd5);
        check_no_req("b_halt_noreq");
        chk("b_ret_q_empty", 32'(ret_q.size()), 0);
        chk("b_dm_q_empty", 32'(dm_q.size()), 0);

        // ---------- Run C: reset during a pending fetch ----------
        Reset = 1'b0;
        clear_mem();
        iwait = 50; dwait = 0;
        put(16'h40, ei(6'h08, 5'd0, 5'd1, 16'd9));
        put(16'h44, HALT_W);
        repeat (2) @(negedge CLK);
        #1 Reset = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        chk("c_req_pending", 32'(imem_req), 1);
        chk("c_req_addr", 32'(imem_addr), 32'h40);
        Reset = 1'b0;
        #1;
        chk("c_req_drop", 32'(imem_req), 0);
        manual = 1'b1;
        imem_rdata = ei(6'h08, 5'd0, 5'd1, 16'h77);
        imem_ack = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #2;
        chk("c_late_ack_state", 32'(dbg_state), 0);
        chk("c_late_ack_pc", 32'(dbg_pc), 32'h40);
        imem_ack = 1'b0;
        iwait = 0;
        exp_ret(16'h40, 4);
        @(negedge CLK); #1;
        Reset = 1'b1;
        manual = 1'b0;
        @(posedge CLK); #2;
        chk("c_restart_addr", 32'(imem_addr), 32'h40);
        wait_halt("c_halted");
        chk("c_illegal", 32'(illegal), 0);
        chk("c_dbg_reg", 32'(dbg_reg), 32'd9);
        chk("c_ret_q_empty", 32'(ret_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_cpu_core.md
Name: mc_cpu_core

Overview:
Parametrised multi-cycle MIPS-subset CPU core, the next generation of the current multi-cycle top. It replaces the internal instruction/data memories with external req/ack buses, so memories of any latency (wait states) can be attached. It adds a HALT state, illegal-opcode trap, retire pulse and parametrised PC width and reset vector. Instantiated by the board top, which supplies the memories and drives the 7-segment debug mux from the dbg_* ports.

Parameters:
ADDR_W, 32, PC and memory address width (8..32); all PC arithmetic is modulo 2^ADDR_W.
RESET_PC, 0, PC value after reset (word aligned, ADDR_W bits).
DBG_REG, 1, register index whose low byte is exported on dbg_reg.

Ports:
CLK  in  1  clock; all state updates on the falling edge (negedge), as in the rest of the codebase.
Reset  in  1  asynchronous, active-low reset.
imem_req  out  1  instruction fetch request.
imem_addr  out  ADDR_W  fetch address (= PC).
imem_rdata  in  32  instruction word, valid when imem_ack=1.
imem_ack  in  1  fetch complete.
dmem_req  out  1  data access request.
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
dmem_addr  out  ADDR_W  data address (ALUOut truncated).
dmem_wdata  out  32  store data (B register).
dmem_rdata  in  32  load data, valid when dmem_ack=1.
dmem_ack  in  1  data access complete.
retire  out  1  one-cycle pulse in the last cycle of each completed instruction.
halted  out  1  core is in HALT.
illegal  out  1  sticky; set when HALT was entered via an undefined opcode.
dbg_pc  out  ADDR_W  current PC.
dbg_state  out  3  FSM state encoding (IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=7).
dbg_reg  out  8  low byte of register DBG_REG.

Behaviour:
- Reset (async, Reset=0): state=IF, PC=RESET_PC, IR=0, r0..r31=0, A/B/ALUOut/MDR=0, imem_req=dmem_req=dmem_we=0, retire=halted=illegal=0. Reset asserted mid-transaction drops req immediately; the transaction is abandoned.
- Handshake: req is a decode of state and stays high until a cycle with req=1 and ack=1 (zero-wait ack in the same cycle is legal). Address, we and wdata are held stable while req=1. An ack without req is ignored.
- IF: imem_req=1; on ack, IR<=imem_rdata, PC<=PC+4, go to ID. ID: A<=rs, B<=rt, decode.
- ISA (MIPS encoding): R-type op 0x00 with funct add 20, sub 22, and 24, or 25, slt 2A (signed), sll 00 (rt<<sa), jr 08; addi 08 (sign-extend), ori 0D (zero-extend), lw 23, sw 2B, beq 04, bne 05, j 02, jal 03, halt 3F. Any other op or R funct -> HALT with illegal=1.
- Paths (cycles excluding wait states): R/addi/ori IF-ID-EXE-WB = 4; lw IF-ID-EXE-MEM-WB = 5; sw IF-ID-EXE-MEM = 4; beq/bne IF-ID-EXE = 3; j/jal/jr IF-ID = 2; halt IF-ID -> HALT.
- EXE: ALUOut<=ALU result. Branch taken: PC<=PC+(sext(imm)<<2), where PC already holds PC+4. Address = A+sext(imm).
- ID jumps: j PC<={(PC+4)[ADDR_W-1:28], target, 2'b00} truncated to ADDR_W; jal also writes r31<=zero-extended PC+4; jr PC<=A[ADDR_W-1:0].
- MEM: dmem_req=1, dmem_we=1 for sw; the lw result is written to the register file in WB. WB: writes rd (R-type) or rt (I-type). Writes to r0 are discarded; r0 always reads 0.
- Register file: read asynchronously in ID; write on the clock edge leaving WB/ID.
- retire pulses in the completing state's final (acked) cycle; it never fires on HALT entry.
- HALT: absorbing; no requests issued; only Reset exits.
- Overflow ignored (add/addi wrap); PC wraps modulo 2^ADDR_W.

Test Plan:
1. Reset with RESET_PC=0x40, zero-wait memory -> first imem_addr=0x40; dbg_state=0; all outputs 0 while Reset=0.
2. addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> r3=2, r4=1; retire every 4 cycles; writes to r0 leave it 0.
3. sw r1,8(r0) then lw r5,8(r0), with memory acking after 3 wait cycles -> dmem_addr=8, dmem_wdata=5, r5=5; sw takes 4+3+3 cycles, lw 5+3+3; req held stable across waits.
4. beq r1,r1,-1 at 0x10 -> next fetch 0x10; bne not taken -> 0x14; jal 0x100 at 0x20 -> r31=0x24, then jr r31 -> PC=0x24.
5. Opcode 0x3F -> halted=1, illegal=0, no further imem_req; undefined opcode 0x3E -> halted=1, illegal=1.
6. Reset asserted while imem_req=1 and awaiting ack -> imem_req drops immediately; after release, fetch restarts at RESET_PC and the late ack is ignored.
